// File: rtl/uvmt_i2c_st_clknrst_pkg.sv
// Shared types for the I2C self-test clock/reset sequencer.
// Configuration macro used by the design: UVMT_I2C_ST_CLKNRST_GLITCHFREE_EN.
package uvmt_i2c_st_clknrst_pkg;

    // Command opcodes carried on cfg_op; OP_RSVD is accepted but does nothing
    typedef enum logic [1:0] {
        SET_DIV   = 2'd0,
        RST_PULSE = 2'd1,
        STOP      = 2'd2,
        OP_RSVD   = 2'd3
    } cfg_op_e;

    // Per-channel sequencing state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/uvmt_i2c_st_clknrst_ch.sv
// One output channel: clock divider, reset-hold counter and channel FSM.
// With UVMT_I2C_ST_CLKNRST_GLITCHFREE_EN defined, divisor changes on a running
// channel are deferred to the next falling divided-clock edge.
module uvmt_i2c_st_clknrst_ch
    import uvmt_i2c_st_clknrst_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int RST_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  cfg_op_e          cmd_op,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic [RST_W-1:0] cmd_rst,
    output logic             ch_clk,
    output logic             ch_tick,
    output logic             ch_reset_n,
    output logic             ch_running,
    output logic             pending
);

    ch_state_e        state;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_cnt;
    logic [RST_W-1:0] hold_cnt;
    logic             wrap;
    logic             cmd_effective;

    // The divider only ever runs with div != 0, so div-1 never underflows while active
    assign wrap          = (div_cnt == div - DIV_W'(1));
    assign cmd_effective = cmd_valid && (cmd_op != OP_RSVD);

`ifdef UVMT_I2C_ST_CLKNRST_GLITCHFREE_EN
    logic [DIV_W-1:0] pend_div;
    logic             pend_flag;

    assign pending = pend_flag;

    // Channel FSM, divider and hold counter; a new divisor waits for the next falling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            div        <= '0;
            div_cnt    <= '0;
            hold_cnt   <= '0;
            ch_clk     <= 1'b0;
            ch_tick    <= 1'b0;
            ch_reset_n <= 1'b0;
            ch_running <= 1'b0;
            pend_div   <= '0;
            pend_flag  <= 1'b0;
        end else begin
            ch_tick <= 1'b0;
            if (state != IDLE) begin
                if (wrap) begin
                    div_cnt <= '0;
                    ch_clk  <= ~ch_clk;
                    ch_tick <= ~ch_clk;
                    if (ch_clk && pend_flag) begin
                        div       <= pend_div;
                        pend_flag <= 1'b0;
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
            if (state == HOLD && ch_tick && !cmd_effective) begin
                if (hold_cnt == '0) begin
                    state      <= RUN;
                    ch_reset_n <= 1'b1;
                    ch_running <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt - RST_W'(1);
                end
            end
            if (cmd_valid) begin
                case (cmd_op)
                    SET_DIV: begin
                        if (cmd_div == '0) begin
                            div        <= '0;
                            state      <= IDLE;
                            div_cnt    <= '0;
                            ch_clk     <= 1'b0;
                            ch_tick    <= 1'b0;
                            ch_reset_n <= 1'b0;
                            ch_running <= 1'b0;
                            pend_flag  <= 1'b0;
                        end else if (state == IDLE) begin
                            div <= cmd_div;
                        end else begin
                            pend_div  <= cmd_div;
                            pend_flag <= 1'b1;
                        end
                    end
                    RST_PULSE: begin
                        if (div != '0) begin
                            state      <= HOLD;
                            hold_cnt   <= cmd_rst;
                            ch_reset_n <= 1'b0;
                            ch_running <= 1'b0;
                            if (state == IDLE) begin
                                div_cnt <= '0;
                                ch_clk  <= 1'b0;
                                ch_tick <= 1'b0;
                            end
                        end
                    end
                    STOP: begin
                        state      <= IDLE;
                        div_cnt    <= '0;
                        ch_clk     <= 1'b0;
                        ch_tick    <= 1'b0;
                        ch_reset_n <= 1'b0;
                        ch_running <= 1'b0;
                        pend_flag  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
`else
    assign pending = 1'b0;

    // Channel FSM, divider and hold counter; a new divisor takes effect at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            div        <= '0;
            div_cnt    <= '0;
            hold_cnt   <= '0;
            ch_clk     <= 1'b0;
            ch_tick    <= 1'b0;
            ch_reset_n <= 1'b0;
            ch_running <= 1'b0;
        end else begin
            ch_tick <= 1'b0;
            if (state != IDLE) begin
                if (wrap) begin
                    div_cnt <= '0;
                    ch_clk  <= ~ch_clk;
                    ch_tick <= ~ch_clk;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
            if (state == HOLD && ch_tick && !cmd_effective) begin
                if (hold_cnt == '0) begin
                    state      <= RUN;
                    ch_reset_n <= 1'b1;
                    ch_running <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt - RST_W'(1);
                end
            end
            if (cmd_valid) begin
                case (cmd_op)
                    SET_DIV: begin
                        div <= cmd_div;
                        if (cmd_div == '0) begin
                            state      <= IDLE;
                            div_cnt    <= '0;
                            ch_clk     <= 1'b0;
                            ch_tick    <= 1'b0;
                            ch_reset_n <= 1'b0;
                            ch_running <= 1'b0;
                        end else if (state != IDLE) begin
                            div_cnt <= '0;
                        end
                    end
                    RST_PULSE: begin
                        if (div != '0) begin
                            state      <= HOLD;
                            hold_cnt   <= cmd_rst;
                            ch_reset_n <= 1'b0;
                            ch_running <= 1'b0;
                            if (state == IDLE) begin
                                div_cnt <= '0;
                                ch_clk  <= 1'b0;
                                ch_tick <= 1'b0;
                            end
                        end
                    end
                    STOP: begin
                        state      <= IDLE;
                        div_cnt    <= '0;
                        ch_clk     <= 1'b0;
                        ch_tick    <= 1'b0;
                        ch_reset_n <= 1'b0;
                        ch_running <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: rtl/uvmt_i2c_st_clknrst_seq.sv
// Multi-channel clock-divider and reset sequencer for the I2C self-test bench.
// Optional deferred divisor update: UVMT_I2C_ST_CLKNRST_GLITCHFREE_EN.
module uvmt_i2c_st_clknrst_seq
    import uvmt_i2c_st_clknrst_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8,
    parameter int RST_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_op,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [RST_W-1:0]  cfg_rst,
    output logic [NUM_CH-1:0] ch_clk,
    output logic [NUM_CH-1:0] ch_tick,
    output logic [NUM_CH-1:0] ch_reset_n,
    output logic [NUM_CH-1:0] ch_running
);

    logic [NUM_CH-1:0] ch_pending;
    logic              accept;

    assign accept = cfg_valid && cfg_ready;

    // Back-pressure only the addressed channel while its divisor update is pending
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i) && ch_pending[i]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        uvmt_i2c_st_clknrst_ch #(
            .DIV_W (DIV_W),
            .RST_W (RST_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .cmd_valid  (accept && (cfg_ch == CH_W'(g))),
            .cmd_op     (cfg_op_e'(cfg_op)),
            .cmd_div    (cfg_div),
            .cmd_rst    (cfg_rst),
            .ch_clk     (ch_clk[g]),
            .ch_tick    (ch_tick[g]),
            .ch_reset_n (ch_reset_n[g]),
            .ch_running (ch_running[g]),
            .pending    (ch_pending[g])
        );
    end

endmodule

// File: doc/uvmt_i2c_st_clknrst_seq.md
# uvmt_i2c_st_clknrst_seq

Synthesizable multi-channel clock-divider and reset sequencer for the I2C self-test bench. It derives NUM_CH divided clocks from one bench clock. Each divided clock has its own active-low reset, which is released a programmable number of divided-clock edges after the clock starts. Test cases program it through a valid/ready command port; it replaces ad-hoc per-interface clock/reset generation.

## Interface
Parameters:
- NUM_CH, 2, number of independent output channels (≥1)
- DIV_W, 8, width of the half-period divisor
- RST_W, 8, width of the reset-hold count
- CH_W, $clog2(NUM_CH) (min 1), width of the channel index (derived)

Ports:
- clk  in  1  bench clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  command valid
- cfg_ready  out  1  command ready; transfer occurs when valid && ready
- cfg_op  in  2  command: 0 SET_DIV, 1 RST_PULSE, 2 STOP, 3 reserved (accepted, no effect)
- cfg_ch  in  CH_W  target channel; values ≥NUM_CH are accepted and ignored
- cfg_div  in  DIV_W  half-period in clk cycles (SET_DIV)
- cfg_rst  in  RST_W  reset-hold count R (RST_PULSE)
- ch_clk  out  NUM_CH  divided clocks
- ch_tick  out  NUM_CH  one-cycle pulse coincident with each ch_clk rising transition
- ch_reset_n  out  NUM_CH  per-channel active-low reset
- ch_running  out  NUM_CH  channel state is RUN

## Operation
- Per-channel registers: div (DIV_W), div_cnt (DIV_W), hold_cnt (RST_W), state.
- States:
  - IDLE: ch_clk=0, ch_reset_n=0.
  - HOLD: clock runs, ch_reset_n=0.
  - RUN: clock runs, ch_reset_n=1.
- Divider, active in HOLD and RUN:
  - div_cnt counts 0..div-1.
  - At div-1, div_cnt wraps to 0 and ch_clk toggles, giving period 2·div and 50% duty.
  - ch_tick=1 in the cycle ch_clk becomes 1.
- SET_DIV:
  - Stores div.
  - cfg_div=0 forces IDLE (clock gated).
  - Otherwise the state is unchanged, and an IDLE channel stays IDLE.
- RST_PULSE:
  - With div≠0: enters HOLD, loads hold_cnt=R.
    - From IDLE, also clears div_cnt and sets ch_clk=0.
    - From RUN, ch_clk continues undisturbed.
  - With div=0: ignored.
- STOP: any state → IDLE; ch_clk=0 and ch_reset_n=0 the next cycle.
- HOLD counting:
  - On each tick: hold_cnt==0 → RUN; otherwise hold_cnt decrements.
  - ch_reset_n therefore rises the cycle after the (R+1)-th tick, aligned to a divided-clock rising edge.
- cfg_ready=1 always, except as stated under Configuration.
- Simultaneous events: a command accepted in the same cycle as a tick on the same channel takes priority. That tick's hold decrement and RUN transition are discarded; the ch_clk toggle still occurs unless the command is STOP or forces IDLE.

## Timing
- Reset values: ch_clk=0, ch_tick=0, ch_reset_n=0, ch_running=0, cfg_ready=1, all states IDLE, div=0.
- reset acts immediately (asynchronous).
- All outputs are registered; no combinational path from cfg_* to channel outputs.
- cfg_ready may combinationally depend on cfg_ch.
- Command accepted at edge N → state/registers updated at N. From IDLE, the first ch_clk rise (and ch_tick) occurs at edge N+div.
- Mid-operation reset returns every channel to IDLE; commands in flight are lost.

## Configuration
Macro: UVMT_I2C_ST_CLKNRST_GLITCHFREE_EN.

- Defined:
  - SET_DIV with cfg_div≠0 on a HOLD/RUN channel stores the value as pending and sets a per-channel pending flag.
  - The pending value is applied (div_cnt cleared) on the next ch_clk 1→0 toggle, so no phase is shorter than min(old, new).
  - cfg_ready=0 while pending[cfg_ch]=1.
  - STOP and cfg_div=0 act immediately and clear pending.
- Undefined:
  - SET_DIV loads div and clears div_cnt at once; the current phase may be truncated.
  - No pending flag exists; cfg_ready is constant 1.

## Structure
- Package uvmt_i2c_st_clknrst_pkg:
  - enum for cfg_op (SET_DIV/RST_PULSE/STOP)
  - enum for channel state (IDLE/HOLD/RUN)
- Sub-module uvmt_i2c_st_clknrst_ch implements one channel (divider, hold counter, FSM, pending logic).
- The top decodes cfg_ch and instantiates the sub-module NUM_CH times via generate.
- The top ORs/aggregates ready.

## Test plan
- Reset, then SET_DIV ch0 div=3, RST_PULSE ch0 R=2 → ch_clk period 6 clk; ch_tick at 3, 9, 15 cycles after accept; ch_reset_n rises one cycle after the 3rd tick; ch1 stays clk=0, reset_n=0.
- SET_DIV ch1 div=1, RST_PULSE R=0 → ch1 toggles every cycle; ch_reset_n rises after the first tick; ch0 unaffected.
- RUN channel, RST_PULSE R=1 → ch_reset_n falls next cycle, ch_clk uninterrupted, rises again after 2 ticks; STOP → clk and reset_n low next cycle.
- GLITCHFREE_EN: div=4 running, SET_DIV 2 mid-high phase → cfg_ready low, high phase stays 4 cycles, subsequent phases 2, ready returns; without macro the phase truncates immediately.
- Edge cases: RST_PULSE with div=0, cfg_ch≥NUM_CH, op=3 → no output change; RST_PULSE coincident with tick in HOLD → hold reloads, no RUN.
- Assert reset mid-RUN → all outputs at reset values immediately; after deassertion, channels remain IDLE until reprogrammed.
